led_blink_decoder: RTL

Receive-side counterpart to the LED blinker. Samples a square-wave LED drive signal, measures the interval between its toggles, and decodes which of the four blink rates (100/50/10/1 Hz at a 25 kHz clock) is present. The result is reported as the same 2-bit switch code the blinker uses, so a board can loop-back verify its blinker or read a blink-coded status line from another device.

---
 rtl/led_blink_decoder_if.sv | 13 +
 rtl/led_blink_decoder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/led_blink_decoder_if.sv
// Blink-line bundle: the raw LED input and the decoded rate status.
interface led_blink_decoder_if;
   logic       i_led;
   logic [1:0] o_select;
   logic       o_valid;
   logic       o_idle;
   logic       o_error;

   // master drives the blink line and watches the status
   modport master (output i_led, input o_select, o_valid, o_idle, o_error);
   // slave is the decoder
   modport slave  (input i_led, output o_select, o_valid, o_idle, o_error);
endinterface

// File: rtl/led_blink_decoder.sv
// Decodes an LED blink rate (100/50/10/1 Hz at 25 kHz) back into the
// blinker's 2-bit switch code by timing the gaps between toggles.
module led_blink_decoder #(
   parameter int unsigned c_CNT_100HZ = 125,
   parameter int unsigned c_CNT_50HZ  = 250,
   parameter int unsigned c_CNT_10HZ  = 1250,
   parameter int unsigned c_CNT_1HZ   = 12500
) (
   input  logic               i_clock,
   input  logic               i_rst_n,
   led_blink_decoder_if.slave bus
);
   localparam logic [31:0] N0 = c_CNT_100HZ;
   localparam logic [31:0] N1 = c_CNT_50HZ;
   localparam logic [31:0] N2 = c_CNT_10HZ;
   localparam logic [31:0] N3 = c_CNT_1HZ;
   // +/- 1/8 acceptance windows, inclusive on both ends
   localparam logic [31:0] LO0 = N0 - (N0 >> 3);
   localparam logic [31:0] HI0 = N0 + (N0 >> 3);
   localparam logic [31:0] LO1 = N1 - (N1 >> 3);
   localparam logic [31:0] HI1 = N1 + (N1 >> 3);
   localparam logic [31:0] LO2 = N2 - (N2 >> 3);
   localparam logic [31:0] HI2 = N2 + (N2 >> 3);
   localparam logic [31:0] LO3 = N3 - (N3 >> 3);
   localparam logic [31:0] HI3 = N3 + (N3 >> 3);
   // longest legal interval; anything past it means the line went quiet
   localparam logic [31:0] LIMIT = HI3;

   typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_CHECK, S_LOCKED} state_t;

   state_t      state, state_nxt;
   logic [2:0]  sync_pipe;   // [0],[1] synchronizer, [2] previous sample
   logic        edge_det;
   logic [31:0] cnt;
   logic [1:0]  cls, cls_nxt;
   logic [1:0]  sel, sel_nxt;
   logic        err, err_nxt;
   logic        hit_vld;
   logic [1:0]  hit_cls;

   // bring the asynchronous LED line into the clock domain, keep one old sample
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) sync_pipe <= '0;
      else          sync_pipe <= {sync_pipe[1:0], bus.i_led};
   end

   assign edge_det = sync_pipe[2] ^ sync_pipe[1];

   // interval counter: reads the gap length on an edge, then restarts at 1
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n)          cnt <= '0;
      else if (edge_det)     cnt <= 32'd1;
      else if (cnt != '1)    cnt <= cnt + 32'd1;
   end

   // classify the current count against the four rate windows
   always_comb begin
      hit_vld = 1'b1;
      hit_cls = 2'b00;
      if      (cnt >= LO0 && cnt <= HI0) hit_cls = 2'b00;
      else if (cnt >= LO1 && cnt <= HI1) hit_cls = 2'b01;
      else if (cnt >= LO2 && cnt <= HI2) hit_cls = 2'b10;
      else if (cnt >= LO3 && cnt <= HI3) hit_cls = 2'b11;
      else                               hit_vld = 1'b0;
   end

   // state, candidate class, locked code and error pulse registers
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
         cls   <= 2'b00;
         sel   <= 2'b00;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cls   <= cls_nxt;
         sel   <= sel_nxt;
         err   <= err_nxt;
      end
   end

   // lock FSM; an edge landing exactly at LIMIT still counts because the
   // timeout only fires once the count is strictly beyond it
   always_comb begin
      state_nxt = state;
      cls_nxt   = cls;
      sel_nxt   = sel;
      err_nxt   = 1'b0;
      if (state != S_IDLE && cnt > LIMIT) begin
         state_nxt = S_IDLE;
      end else if (edge_det) begin
         unique case (state)
            S_IDLE: state_nxt = S_ACQUIRE;   // first edge: nothing measured yet
            S_ACQUIRE: begin
               if (hit_vld) begin
                  cls_nxt   = hit_cls;
                  state_nxt = S_CHECK;
               end else begin
                  err_nxt = 1'b1;
               end
            end
            S_CHECK: begin
               if (!hit_vld) begin
                  err_nxt   = 1'b1;
                  state_nxt = S_ACQUIRE;
               end else if (hit_cls == cls) begin
                  sel_nxt   = hit_cls;
                  state_nxt = S_LOCKED;
               end else begin
                  cls_nxt = hit_cls;
               end
            end
            S_LOCKED: begin
               if (!hit_vld) begin
                  err_nxt   = 1'b1;
                  state_nxt = S_ACQUIRE;
               end else if (hit_cls != cls) begin
                  cls_nxt   = hit_cls;
                  state_nxt = S_CHECK;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign bus.o_select = sel;
   assign bus.o_valid  = (state == S_LOCKED);
   assign bus.o_idle   = (state == S_IDLE);
   assign bus.o_error  = err;
endmodule
